// File: rtl/ysyx_22041207_axi_mem_responder.sv
// LSU memory-channel responder: fixed-latency, byte-maskable 64-bit RAM.
// One outstanding request; write wins over read in the same cycle.
module ysyx_22041207_axi_mem_responder #(
    parameter int          DEPTH = 512,
    parameter logic [63:0] BASE  = 64'h8000_0000,
    parameter int          LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    input  logic [63:0] w_addr_i,
    input  logic [63:0] w_data_i,
    input  logic [7:0]  w_mask_i,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    input  logic        rx_r_valid_i,
    output logic        rx_r_ready_o,
    input  logic [63:0] rx_r_addr_i,
    input  logic [7:0]  rx_r_size_i,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    output logic [63:0] rx_data_read_o,
    output logic        err_o
);
    localparam int          IW    = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    typedef enum logic [2:0] {
        IDLE, W_WAIT, W_RESP, R_WAIT, R_RESP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr, r_wdata;
    logic [7:0]  r_mask, r_size;
    logic [63:0] r_mem [DEPTH];

    logic          w_acc_w, w_acc_r, w_fire, w_hit, w_size_ok;
    logic [63:0]   w_off, w_word, w_shift, w_lane, w_rdata;
    logic [IW-1:0] w_idx;
    logic          w_unused;

    assign w_off    = r_addr - BASE;
    assign w_idx    = w_off[IW+2:3];
    assign w_hit    = (r_addr >= BASE) && (r_addr < LIMIT);
    assign w_word   = r_mem[w_idx];
    assign w_shift  = w_word >> {r_addr[2:0], 3'b000};
    assign w_rdata  = w_hit ? (w_shift & w_lane) : 64'h0;
    assign w_unused = ^{w_off[63:IW+3], w_off[2:0]};

    // Illegal sizes read the full doubleword and flag an error.
    always_comb begin
        w_lane    = '1;
        w_size_ok = 1'b1;
        case (r_size)
            8'd1:    w_lane = 64'h0000_0000_0000_00FF;
            8'd2:    w_lane = 64'h0000_0000_0000_FFFF;
            8'd4:    w_lane = 64'h0000_0000_FFFF_FFFF;
            8'd8:    w_lane = '1;
            default: w_size_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_w     = 1'b0;
        w_acc_r     = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid_i) begin
                    w_acc_w     = 1'b1;
                    w_state_nxt = W_WAIT;
                end else if (rx_r_valid_i) begin
                    w_acc_r     = 1'b1;
                    w_state_nxt = R_WAIT;
                end
            end
            W_WAIT: if (r_cnt == 4'd0) begin
                w_fire      = 1'b1;
                w_state_nxt = W_RESP;
            end
            W_RESP: if (w_ready_i) w_state_nxt = IDLE;
            R_WAIT: if (r_cnt == 4'd0) begin
                w_fire      = 1'b1;
                w_state_nxt = R_RESP;
            end
            R_RESP: if (rx_data_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ready_o      <= 1'b0;
            w_valid_o      <= 1'b0;
            rx_r_ready_o   <= 1'b0;
            rx_data_valid  <= 1'b0;
            rx_data_read_o <= 64'h0;
            err_o          <= 1'b0;
            r_cnt          <= 4'd0;
            r_addr         <= 64'h0;
            r_wdata        <= 64'h0;
            r_mask         <= 8'h0;
            r_size         <= 8'h0;
        end else begin
            w_ready_o    <= 1'b0;
            rx_r_ready_o <= 1'b0;
            err_o        <= 1'b0;
            if (w_acc_w) begin
                r_addr    <= w_addr_i;
                r_wdata   <= w_data_i;
                r_mask    <= w_mask_i;
                r_cnt     <= 4'(LAT);
                w_ready_o <= 1'b1;
            end
            if (w_acc_r) begin
                r_addr       <= rx_r_addr_i;
                r_size       <= rx_r_size_i;
                r_cnt        <= 4'(LAT);
                rx_r_ready_o <= 1'b1;
            end
            if ((r_state == W_WAIT || r_state == R_WAIT) && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_fire && r_state == W_WAIT) begin
                w_valid_o <= 1'b1;
                err_o     <= !w_hit;
            end
            if (w_fire && r_state == R_WAIT) begin
                rx_data_valid  <= 1'b1;
                rx_data_read_o <= w_rdata;
                err_o          <= !w_hit || !w_size_ok;
            end
            if (r_state == W_RESP && w_ready_i)     w_valid_o     <= 1'b0;
            if (r_state == R_RESP && rx_data_ready) rx_data_valid <= 1'b0;
        end
    end

    // Commit is gated by rst_n so a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (rst_n && w_fire && r_state == W_WAIT && w_hit) begin
            for (int b = 0; b < 8; b++) begin
                if (r_mask[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_axi_mem_responder.sv
// Directed bench for the LSU memory responder (LAT=2, BASE=0x8000_0000).
module tb_ysyx_22041207_axi_mem_responder;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_valid_i = 1'b0, w_ready_o, w_valid_o, w_ready_i = 1'b0;
    logic [63:0] w_addr_i = '0, w_data_i = '0;
    logic [7:0]  w_mask_i = '0;
    logic        rx_r_valid_i = 1'b0, rx_r_ready_o;
    logic [63:0] rx_r_addr_i = '0, rx_data_read_o;
    logic [7:0]  rx_r_size_i = '0;
    logic        rx_data_valid, rx_data_ready = 1'b0, err_o;

    int n_chk = 0;
    int n_err = 0;

    ysyx_22041207_axi_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
        .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
        .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .rx_data_read_o(rx_data_read_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m, output logic e);
        int n;
        e = 1'b0;
        w_addr_i = a; w_data_i = d; w_mask_i = m; w_valid_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!w_ready_o && n < 50);
        chk("w_accept", w_ready_o, 1);
        w_valid_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!w_valid_o && n < 50);
        chk("w_done", w_valid_o, 1);
        e = err_o;
        w_ready_i = 1'b1;
        tick();
        w_ready_i = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] s,
                           output logic [63:0] d, output logic e);
        int n;
        rx_r_addr_i = a; rx_r_size_i = s; rx_r_valid_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!rx_r_ready_o && n < 50);
        chk("r_accept", rx_r_ready_o, 1);
        rx_r_valid_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!rx_data_valid && n < 50);
        chk("r_valid", rx_data_valid, 1);
        d = rx_data_read_o;
        e = err_o;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
    endtask

    logic [63:0] d;
    logic        e;
    logic        seen;

    initial begin
        repeat (3) tick();
        chk("rst_outs", {59'd0, w_ready_o, w_valid_o, rx_r_ready_o,
                         rx_data_valid, err_o}, 0);
        chk("rst_data", rx_data_read_o, 0);
        rst_n = 1'b1;
        tick();

        do_write(BASE, 64'h1122_3344_5566_7788, 8'hFF, e);
        chk("t1_werr", e, 0);
        do_read(BASE, 8'd8, d, e);
        chk("t1_rd", d, 64'h1122_3344_5566_7788);
        chk("t1_rerr", e, 0);

        do_write(BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, e);
        do_write(BASE + 8, 64'h1234_5678_AABB_9ABC, 8'h0C, e);
        do_read(BASE + 8, 8'd8, d, e);
        chk("t2_mask", d, 64'hFFFF_FFFF_AABB_FFFF);
        do_write(BASE + 8, 64'h0, 8'h00, e);
        chk("t2_m0err", e, 0);
        do_read(BASE + 8, 8'd8, d, e);
        chk("t2_mask0", d, 64'hFFFF_FFFF_AABB_FFFF);

        do_read(BASE + 3, 8'd1, d, e);
        chk("t3_b", d, 64'h55);
        do_read(BASE + 4, 8'd4, d, e);
        chk("t3_w", d, 64'h1122_3344);
        do_read(BASE + 1, 8'd2, d, e);
        chk("t3_h", d, 64'h6677);
        do_read(BASE + 6, 8'd4, d, e);
        chk("t3_cross", d, 64'h1122);
        do_read(BASE, 8'd3, d, e);
        chk("t3_bsz", d, 64'h1122_3344_5566_7788);
        chk("t3_bszerr", e, 1);

        // Simultaneous requests: write first, read after.
        w_addr_i = BASE + 24; w_data_i = 64'hDEAD_BEEF_0BAD_F00D;
        w_mask_i = 8'hFF; w_valid_i = 1'b1;
        rx_r_addr_i = BASE + 24; rx_r_size_i = 8'd8; rx_r_valid_i = 1'b1;
        tick();
        chk("t4_wacc", w_ready_o, 1);
        chk("t4_rnoacc", rx_r_ready_o, 0);
        w_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !w_valid_o; i++) begin
            tick();
            seen |= rx_r_ready_o;
        end
        chk("t4_wdone", w_valid_o, 1);
        w_ready_i = 1'b1;
        tick();
        w_ready_i = 1'b0;
        chk("t4_rheld", seen, 0);
        for (int i = 0; i < 50 && !rx_r_ready_o; i++) tick();
        chk("t4_racc", rx_r_ready_o, 1);
        rx_r_valid_i = 1'b0;
        for (int i = 0; i < 50 && !rx_data_valid; i++) tick();
        chk("t4_rdata", rx_data_read_o, 64'hDEAD_BEEF_0BAD_F00D);
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;

        // Cycle-exact write timing and backpressure.
        w_addr_i = BASE + 32; w_data_i = 64'h1; w_mask_i = 8'hFF;
        w_valid_i = 1'b1;
        chk("t5_pre", w_ready_o, 0);
        tick();
        chk("t5_rdy", w_ready_o, 1);
        w_valid_i = 1'b0;
        tick();
        chk("t5_rdy_drop", {w_ready_o, w_valid_o}, 0);
        tick();
        chk("t5_v_early", w_valid_o, 0);
        tick();
        chk("t5_v_rise", w_valid_o, 1);
        chk("t5_err", err_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold", w_valid_o, 1);
        end
        w_ready_i = 1'b1;
        tick();
        w_ready_i = 1'b0;
        chk("t5_drop", w_valid_o, 0);

        do_write(BASE + 64'd4096, 64'h5, 8'hFF, e);
        chk("t6_wrange", e, 1);
        do_read(BASE + 64'd4096, 8'd8, d, e);
        chk("t6_rhi", d, 0);
        chk("t6_rhierr", e, 1);
        do_read(64'h0, 8'd8, d, e);
        chk("t6_r0", d, 0);
        chk("t6_r0err", e, 1);
        tick();
        chk("t6_errpulse", err_o, 0);

        // Reset during R_WAIT after data output is non-zero.
        do_read(BASE, 8'd8, d, e);
        rx_r_addr_i = BASE; rx_r_size_i = 8'd8; rx_r_valid_i = 1'b1;
        tick();
        chk("t6_racc", rx_r_ready_o, 1);
        rx_r_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t6_rst_outs", {59'd0, w_ready_o, w_valid_o, rx_r_ready_o,
                            rx_data_valid, err_o}, 0);
        chk("t6_rst_data", rx_data_read_o, 0);
        rst_n = 1'b1;
        tick();

        // Reset during W_WAIT must drop the pending write.
        do_write(BASE + 16, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, e);
        w_addr_i = BASE + 16; w_data_i = 64'h0; w_mask_i = 8'hFF;
        w_valid_i = 1'b1;
        tick();
        w_valid_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_wrst", w_valid_o, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_wrst_idle", w_valid_o, 0);
        do_read(BASE + 16, 8'd8, d, e);
        chk("t6_nocommit", d, 64'hA5A5_A5A5_A5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end
endmodule
